// File: rtl/tdm_pkg.sv
// Shared TDM framing definitions.
// Used by both the receive demux and the transmit-side mux.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } tdm_state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NCH   = 4;

endpackage

// File: rtl/tdm_demux_slot_decoder.sv
// Slot index to one-hot channel enable decoder.
// Purely combinational; all outputs low when en is low.
module slot_decoder #(
  parameter int NCH = 4,
  parameter int SW  = $clog2(NCH)
) (
  input  logic [SW-1:0]  sel_i,
  input  logic           en_i,
  output logic [NCH-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int k = 0; k < NCH; k++) begin
      onehot_o[k] = en_i && (sel_i == SW'(k));
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM receive demultiplexer with sync-qualified frame lock.
// Slot beats are steered into per-channel registers.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               sync,
  output logic [NCH*WIDTH-1:0] ch_data,
  output logic [NCH-1:0]     ch_valid,
  output logic               frame_done,
  output logic               locked,
  output logic               sync_err
);

  localparam int SW = $clog2(NCH);
  localparam logic [SW-1:0] LAST = SW'(NCH - 1);
  localparam logic [SW-1:0] ONE  = SW'(1);

  tdm_state_e           state_q, state_d;
  logic [SW-1:0]        slot_q, slot_d;
  logic [NCH*WIDTH-1:0] ch_data_q;
  logic [NCH-1:0]       ch_valid_q;
  logic                 fdone_q, fdone_d;
  logic                 serr_q, serr_d;
  logic                 wr_en;
  logic [SW-1:0]        wr_slot;
  logic [NCH-1:0]       wr_oh;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    fdone_d = 1'b0;
    serr_d  = 1'b0;
    wr_en   = 1'b0;
    wr_slot = slot_q;
    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            wr_en   = 1'b1;
            wr_slot = '0;
            slot_d  = ONE;
            state_d = LOCK;
          end
        end
        LOCK: begin
          if (sync && slot_q != '0) begin
            serr_d  = 1'b1;
            wr_en   = 1'b1;
            wr_slot = '0;
            slot_d  = ONE;
          end else if (!sync && slot_q == '0) begin
            serr_d  = 1'b1;
            state_d = HUNT;
          end else begin
            wr_en   = 1'b1;
            fdone_d = (slot_q == LAST);
            slot_d  = (slot_q == LAST) ? '0 : slot_q + ONE;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  slot_decoder #(
    .NCH(NCH),
    .SW (SW)
  ) u_dec (
    .sel_i   (wr_slot),
    .en_i    (wr_en),
    .onehot_o(wr_oh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      slot_q     <= '0;
      ch_data_q  <= '0;
      ch_valid_q <= '0;
      fdone_q    <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      ch_valid_q <= wr_oh;
      fdone_q    <= fdone_d;
      serr_q     <= serr_d;
      for (int k = 0; k < NCH; k++) begin
        if (wr_oh[k]) ch_data_q[k*WIDTH +: WIDTH] <= din;
      end
    end
  end

  assign ch_data    = ch_data_q;
  assign ch_valid   = ch_valid_q;
  assign frame_done = fdone_q;
  assign sync_err   = serr_q;
  assign locked     = (state_q == LOCK);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (WIDTH=8, NCH=4).
module tb_tdm_demux;

  logic        clk;
  logic        rst_n;
  logic [7:0]  din;
  logic        din_valid;
  logic        sync;
  logic [31:0] ch_data;
  logic [3:0]  ch_valid;
  logic        frame_done;
  logic        locked;
  logic        sync_err;

  int checks = 0;
  int errors = 0;

  tdm_demux #(.WIDTH(8), .NCH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .sync      (sync),
    .ch_data   (ch_data),
    .ch_valid  (ch_valid),
    .frame_done(frame_done),
    .locked    (locked),
    .sync_err  (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input; return 1ns after the sampling edge.
  task automatic step(input logic v, input logic [7:0] d, input logic s);
    @(negedge clk);
    din_valid = v;
    din       = d;
    sync      = s;
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic [3:0] v,
                      input logic f, input logic l, input logic e);
    check({tag, ".ch_valid"}, 64'(ch_valid), 64'(v));
    check({tag, ".frame_done"}, 64'(frame_done), 64'(f));
    check({tag, ".locked"}, 64'(locked), 64'(l));
    check({tag, ".sync_err"}, 64'(sync_err), 64'(e));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    outs("rst", 4'b0000, 1'b0, 1'b0, 1'b0);
    check("rst.ch_data", 64'(ch_data), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    sync      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    outs("init", 4'b0000, 1'b0, 1'b0, 1'b0);
    check("init.ch_data", 64'(ch_data), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // clean frame
    step(1'b1, 8'h11, 1'b1); outs("cf0", 4'b0001, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h22, 1'b0); outs("cf1", 4'b0010, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h33, 1'b0); outs("cf2", 4'b0100, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h44, 1'b0); outs("cf3", 4'b1000, 1'b1, 1'b1, 1'b0);
    check("cf.ch_data", 64'(ch_data), 64'h44332211);
    step(1'b0, 8'hEE, 1'b1); outs("cf.idle", 4'b0000, 1'b0, 1'b1, 1'b0);

    // gapped frame after a clearing reset
    do_reset();
    step(1'b1, 8'h11, 1'b1); outs("gp0", 4'b0001, 1'b0, 1'b1, 1'b0);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 8'hF0, 1'b1); outs("gp0.gap", 4'b0000, 1'b0, 1'b1, 1'b0);
    end
    step(1'b1, 8'h22, 1'b0); outs("gp1", 4'b0010, 1'b0, 1'b1, 1'b0);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 8'hF1, 1'b0); outs("gp1.gap", 4'b0000, 1'b0, 1'b1, 1'b0);
    end
    step(1'b1, 8'h33, 1'b0); outs("gp2", 4'b0100, 1'b0, 1'b1, 1'b0);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 8'hF2, 1'b1); outs("gp2.gap", 4'b0000, 1'b0, 1'b1, 1'b0);
    end
    step(1'b1, 8'h44, 1'b0); outs("gp3", 4'b1000, 1'b1, 1'b1, 1'b0);
    check("gp.ch_data", 64'(ch_data), 64'h44332211);

    // missing sync at slot 0
    step(1'b1, 8'h77, 1'b0); outs("ms", 4'b0000, 1'b0, 1'b0, 1'b1);
    check("ms.ch_data", 64'(ch_data), 64'h44332211);
    step(1'b0, 8'h00, 1'b0); outs("ms.idle", 4'b0000, 1'b0, 1'b0, 1'b0);

    // hunt
    step(1'b1, 8'hAA, 1'b0); outs("hu0", 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hBB, 1'b0); outs("hu1", 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h11, 1'b1); outs("hu2", 4'b0001, 1'b0, 1'b1, 1'b0);
    check("hu.ch_data", 64'(ch_data), 64'h44332211);

    // early sync resync
    step(1'b1, 8'h22, 1'b0); outs("es1", 4'b0010, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h55, 1'b1); outs("es2", 4'b0001, 1'b0, 1'b1, 1'b1);
    check("es.ch0", 64'(ch_data[7:0]), 64'h55);
    step(1'b1, 8'h66, 1'b0); outs("es3", 4'b0010, 1'b0, 1'b1, 1'b0);
    check("es.ch_data", 64'(ch_data), 64'h44336655);

    // reset mid-frame after slot 2
    step(1'b1, 8'h10, 1'b0); outs("rm2", 4'b0100, 1'b0, 1'b1, 1'b0);
    check("rm.ch_data", 64'(ch_data), 64'h44106655);
    step(1'b0, 8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    outs("rm.async", 4'b0000, 1'b0, 1'b0, 1'b0);
    check("rm.async.ch_data", 64'(ch_data), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h99, 1'b0); outs("rm.99", 4'b0000, 1'b0, 1'b0, 1'b0);
    check("rm.99.ch_data", 64'(ch_data), 64'h0);
    step(1'b1, 8'hC3, 1'b1); outs("rm.c3", 4'b0001, 1'b0, 1'b1, 1'b0);
    check("rm.c3.ch_data", 64'(ch_data), 64'h000000C3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
